// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int MIN_BAUD_DIV = 8;

    // True when the eight data bits plus the received parity bit give the selected sense.
    function automatic logic parity_ok(input logic [7:0] data, input logic par_bit, input logic odd);
        return ((^data) ^ par_bit) == odd;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop on empty is ignored, a push on full is accepted only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            RX,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic                            parity_en,
    input  logic                            parity_odd,
    input  logic                            rd_en,
    output logic [7:0]                      rx_data,
    output logic                            rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun,
    input  logic                            clr_err,
    output rx_state_t                       dbg_state
);
    logic             rx_s1, rx_s2, rx_prev;
    rx_state_t        state, state_nx;
    logic [DIV_W-1:0] baud_cnt, div_q, div_eff;
    logic             par_en_q, par_odd_q, par_bit;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [1:0]       smp;
    logic             tick, maj, start_det;
    logic             start_ld, reload, shift, par_ld;
    logic             push_req, fe_set, pe_set, ov_set;
    logic             fifo_full, fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Only a high-to-low transition starts a frame, so a line stuck low after a break stays quiet.
    assign start_det = rx_prev & ~rx_s2;
    assign tick      = (baud_cnt == '0);
    assign maj       = (smp[1] & smp[0]) | (smp[1] & rx_s2) | (smp[0] & rx_s2);
    assign div_eff   = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_det) state_nx = START;
            START:   if (tick) state_nx = maj ? IDLE : DATA;
            DATA:    if (tick && bit_cnt == 3'd7) state_nx = par_en_q ? PARITY : STOP;
            PARITY:  if (tick) state_nx = STOP;
            STOP:    if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_ld = 1'b0;
        reload   = 1'b0;
        shift    = 1'b0;
        par_ld   = 1'b0;
        push_req = 1'b0;
        fe_set   = 1'b0;
        pe_set   = 1'b0;
        case (state)
            IDLE:   start_ld = start_det;
            START:  reload = tick & ~maj;
            DATA:   begin
                shift  = tick;
                reload = tick;
            end
            PARITY: begin
                par_ld = tick;
                reload = tick;
            end
            STOP:   if (tick) begin
                if (!maj)                                                     fe_set   = 1'b1;
                else if (par_en_q && !parity_ok(shreg, par_bit, par_odd_q)) pe_set   = 1'b1;
                else                                                          push_req = 1'b1;
            end
            default: ;
        endcase
    end

    // A pop in the same cycle frees the slot, so only an unserviced full FIFO drops the byte.
    assign ov_set = push_req & fifo_full & ~rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            smp       <= '0;
        end else begin
            if (start_ld) begin
                baud_cnt  <= div_eff >> 1;
                div_q     <= div_eff;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                bit_cnt   <= '0;
            end else if (reload) begin
                baud_cnt <= div_q - DIV_W'(1);
            end else if (!tick) begin
                baud_cnt <= baud_cnt - DIV_W'(1);
            end
            if (baud_cnt == DIV_W'(2)) smp[1] <= rx_s2;
            if (baud_cnt == DIV_W'(1)) smp[0] <= rx_s2;
            if (shift) begin
                shreg   <= {maj, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_ld) par_bit <= maj;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= fe_set | (frame_err  & ~clr_err);
            parity_err <= pe_set | (parity_err & ~clr_err);
            overrun    <= ov_set | (overrun    & ~clr_err);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (rx_data),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rdy = ~fifo_empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frame driver, queue-based receive model, per-cycle compare.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DIV_W = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        int unsigned ev;
        logic [7:0]  data;
        logic        pe;
        logic        podd;
        logic        pbit;
        logic        stop;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd16;
    logic             parity_en = 1'b0;
    logic             parity_odd = 1'b0;
    logic             clr_err = 1'b0;
    logic             man_rd = 1'b0;
    logic             rand_rd = 1'b0;
    logic             rnd_bit = 1'b0;
    logic             rd_en;
    logic [7:0]       rx_data;
    logic             rdy;
    logic [CW-1:0]    fifo_cnt;
    logic             frame_err, parity_err, overrun;
    rx_state_t        dbg_state;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic        cmp_en = 1'b0;

    frame_t      pend_q[$];
    logic [7:0]  m_q[$];
    logic        m_fe = 1'b0, m_pe = 1'b0, m_ov = 1'b0;
    logic        fe_s, pe_s, ov_s, push_s, pop_s;
    frame_t      cur_f;

    assign rd_en = man_rd | (rand_rd & rnd_bit);

    uart_rx_fifo #(
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (rx),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rd_en      (rd_en),
        .rx_data    (rx_data),
        .rdy        (rdy),
        .fifo_cnt   (fifo_cnt),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .clr_err    (clr_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) == 0);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Posedge index at which a frame whose start bit is driven at the negedge after posedge k
    // is resolved: two sync stages, one cycle to enter START, a half bit to the centre, then whole bits.
    function automatic int unsigned ev_of(input int unsigned k, input int unsigned div, input int unsigned p);
        return k + 4 + div / 2 + (9 + p) * div;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            pend_q.delete();
            m_fe = 1'b0;
            m_pe = 1'b0;
            m_ov = 1'b0;
        end else begin
            fe_s   = 1'b0;
            pe_s   = 1'b0;
            ov_s   = 1'b0;
            push_s = 1'b0;
            pop_s  = rd_en && (m_q.size() != 0);
            if (pend_q.size() != 0 && pend_q[0].ev == cyc + 1) begin
                cur_f = pend_q.pop_front();
                if (!cur_f.stop)
                    fe_s = 1'b1;
                else if (cur_f.pe && ((($countones(cur_f.data) + int'(cur_f.pbit)) % 2) != int'(cur_f.podd)))
                    pe_s = 1'b1;
                else
                    push_s = 1'b1;
            end
            if (pop_s) m_q.delete(0);
            if (push_s) begin
                if (m_q.size() < DEPTH) m_q.push_back(cur_f.data);
                else                    ov_s = 1'b1;
            end
            m_fe = fe_s ? 1'b1 : (clr_err ? 1'b0 : m_fe);
            m_pe = pe_s ? 1'b1 : (clr_err ? 1'b0 : m_pe);
            m_ov = ov_s ? 1'b1 : (clr_err ? 1'b0 : m_ov);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rdy", 32'(rdy), 32'(m_q.size() != 0));
            chk("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
            if (m_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(m_q[0]));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("parity_err", 32'(parity_err), 32'(m_pe));
            chk("overrun", 32'(overrun), 32'(m_ov));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v, input int hold);
        frame_t      f;
        int unsigned div;
        int unsigned p;
        logic        pb;
        div = int'(baud_div);
        p   = parity_en ? 1 : 0;
        pb  = (^d) ^ parity_odd ^ bad_par;
        @(negedge clk);
        f.ev   = ev_of(cyc, div, p);
        f.data = d;
        f.pe   = parity_en;
        f.podd = parity_odd;
        f.pbit = pb;
        f.stop = stop_v;
        pend_q.push_back(f);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (div) @(negedge clk);
        end
        if (p != 0) begin
            rx = pb;
            repeat (div) @(negedge clk);
        end
        rx = stop_v;
        repeat (div) @(negedge clk);
        repeat (hold) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_cyc(input int unsigned target);
        int n = 0;
        while (cyc != target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cyc", cyc, target);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_byte(input logic [7:0] exp);
        chk("read_data", 32'(rx_data), 32'(exp));
        man_rd = 1'b1;
        @(negedge clk);
        man_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int unsigned k;
        int unsigned div;
        int unsigned len;
        @(negedge clk);
        cmp_en = 1'b1;
        idle(3);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_cnt", 32'(fifo_cnt), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);
        chk("reset_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(4);

        // 8N1 at div 16: byte lands exactly at the predicted cycle, then one read empties it
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 0);
            begin
                @(negedge clk);
                k = cyc;
                wait_cyc(ev_of(k, 16, 0) - 1);
                chk("t1_rdy_before", 32'(rdy), 32'd0);
                @(negedge clk);
                chk("t1_rdy_after", 32'(rdy), 32'd1);
            end
        join
        chk("t1_data", 32'(rx_data), 32'hA5);
        chk("t1_cnt", 32'(fifo_cnt), 32'd1);
        read_byte(8'hA5);
        chk("t1_rdy_popped", 32'(rdy), 32'd0);
        idle(3);

        // even parity with a wrong parity bit; clr_err in the same cycle loses to the set
        parity_en = 1'b1;
        parity_odd = 1'b0;
        fork
            send_frame(8'h3C, 1'b1, 1'b1, 0);
            begin
                @(negedge clk);
                k = cyc;
                wait_cyc(ev_of(k, 16, 1) - 1);
                clr_err = 1'b1;
                @(negedge clk);
                clr_err = 1'b0;
            end
        join
        chk("t2_parity_err", 32'(parity_err), 32'd1);
        chk("t2_cnt", 32'(fifo_cnt), 32'd0);
        pulse_clr();
        @(negedge clk);
        chk("t2_parity_clr", 32'(parity_err), 32'd0);
        parity_odd = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("t2_odd_ok", 32'(rx_data), 32'h3C);
        read_byte(8'h3C);
        parity_en = 1'b0;
        idle(3);

        // short low glitch is rejected, the following frame is received normally
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        chk("t3_cnt", 32'(fifo_cnt), 32'd0);
        chk("t3_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        chk("t3_state", 32'(dbg_state), 32'(IDLE));
        send_frame(8'h55, 1'b0, 1'b1, 0);
        read_byte(8'h55);
        idle(3);

        // five bytes into four slots: the fifth is dropped
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 0);
            idle(2);
        end
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_cnt", 32'(fifo_cnt), 32'd4);
        for (int i = 1; i <= 4; i++) read_byte(8'(i));
        chk("t4_empty", 32'(rdy), 32'd0);
        pulse_clr();
        @(negedge clk);
        chk("t4_ov_clr", 32'(overrun), 32'd0);

        // bad stop bit, then the line stays low without retriggering
        send_frame(8'h7E, 1'b0, 1'b0, 40);
        chk("t5_frame_err", 32'(frame_err), 32'd1);
        chk("t5_cnt", 32'(fifo_cnt), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'(IDLE));
        pulse_clr();
        idle(20);

        // full FIFO with a pop in the push cycle: occupancy holds, no overrun
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(8'h10 + i), 1'b0, 1'b1, 0);
            idle(2);
        end
        fork
            send_frame(8'h14, 1'b0, 1'b1, 0);
            begin
                @(negedge clk);
                k = cyc;
                wait_cyc(ev_of(k, 16, 0) - 1);
                man_rd = 1'b1;
                @(negedge clk);
                man_rd = 1'b0;
            end
        join
        chk("t6_cnt", 32'(fifo_cnt), 32'd4);
        chk("t6_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i <= 4; i++) read_byte(8'(8'h10 + i));

        // reset in the middle of a byte with data and a flag pending
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        send_frame(8'h81, 1'b0, 1'b0, 0);
        idle(3);
        @(negedge clk);
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(16);
        rx = 1'b0;
        idle(10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        rx = 1'b1;
        idle(2);
        chk("t6_rst_rdy", 32'(rdy), 32'd0);
        chk("t6_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("t6_rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        chk("t6_rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(4);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        read_byte(8'h5A);

        // randomized frames, line settings and background reads
        rand_rd = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            baud_div   = 16'($urandom_range(8, 20));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            div = int'(baud_div);
            if ($urandom_range(0, 7) == 0) begin
                len = $urandom_range(1, div / 2 - 2);
                rx = 1'b0;
                repeat (len) @(negedge clk);
                rx = 1'b1;
                repeat (2 * div) @(negedge clk);
            end
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 7) != 0), $urandom_range(0, 3));
            idle($urandom_range(2, 6));
            if ($urandom_range(0, 5) == 0) pulse_clr();
        end
        rand_rd = 1'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
